// File: rtl/pipe_front_regs.sv
// pipe_front_regs: PC, IF/ID and ID/EX registers with stall/flush bubbles and per-stage valid bits.
// Defining PIPE_FRONT_PERF_EN adds the StallCnt, FlushDCnt and BubbleCnt counters.
module pipe_front_regs #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CTRL_W    = 12,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              StallF,
    input  logic              StallD,
    input  logic              FlushD,
    input  logic              FlushE,
    input  logic [31:0]       PCNextF,
    input  logic [31:0]       InstrF,
    input  logic [31:0]       PCPlus4F,
    input  logic [CTRL_W-1:0] CtrlD,
    input  logic [31:0]       RD1D,
    input  logic [31:0]       RD2D,
    input  logic [31:0]       ImmExtD,
    input  logic [4:0]        Rs1D,
    input  logic [4:0]        Rs2D,
    input  logic [4:0]        RdD,
    output logic [31:0]       PCF,
    output logic [31:0]       InstrD,
    output logic [31:0]       PCD,
    output logic [31:0]       PCPlus4D,
    output logic              ValidD,
    output logic [CTRL_W-1:0] CtrlE,
    output logic [31:0]       RD1E,
    output logic [31:0]       RD2E,
    output logic [31:0]       ImmExtE,
    output logic [31:0]       PCE,
    output logic [31:0]       PCPlus4E,
    output logic [4:0]        Rs1E,
    output logic [4:0]        Rs2E,
    output logic [4:0]        RdE,
    output logic              ValidE
`ifdef PIPE_FRONT_PERF_EN
    ,
    output logic [31:0]       StallCnt,
    output logic [31:0]       FlushDCnt,
    output logic [31:0]       BubbleCnt
`endif
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            PCF <= RESET_PC;
        else if (!StallF)
            PCF <= PCNextF;
    end

    // flush outranks stall so a wrong-path instruction is discarded rather than held
    always_ff @(posedge clk) begin
        if (!rst_n || FlushD) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            InstrD   <= InstrF;
            PCD      <= PCF;
            PCPlus4D <= PCPlus4F;
            ValidD   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || FlushE) begin
            CtrlE    <= '0;
            RD1E     <= '0;
            RD2E     <= '0;
            ImmExtE  <= '0;
            PCE      <= '0;
            PCPlus4E <= '0;
            Rs1E     <= '0;
            Rs2E     <= '0;
            RdE      <= '0;
            ValidE   <= 1'b0;
        end else begin
            CtrlE    <= CtrlD;
            RD1E     <= RD1D;
            RD2E     <= RD2D;
            ImmExtE  <= ImmExtD;
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
            Rs1E     <= Rs1D;
            Rs2E     <= Rs2D;
            RdE      <= RdD;
            ValidE   <= ValidD;
        end
    end

`ifdef PIPE_FRONT_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            StallCnt  <= '0;
            FlushDCnt <= '0;
            BubbleCnt <= '0;
        end else begin
            StallCnt  <= StallCnt + 32'(StallD && !FlushD);
            FlushDCnt <= FlushDCnt + 32'(FlushD);
            BubbleCnt <= BubbleCnt + 32'(FlushE && ValidD);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_front_regs.sv
// tb_pipe_front_regs: directed stimulus, stage-level model checked every cycle plus literal spot checks.
module tb_pipe_front_regs;
    localparam logic [31:0] RPC = 32'h100;
    localparam int          CW  = 12;
    localparam logic [31:0] NOP = 32'h13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, StallF, StallD, FlushD, FlushE;
    logic [31:0] PCNextF, InstrF, PCPlus4F, RD1D, RD2D, ImmExtD;
    logic [CW-1:0] CtrlD, CtrlE;
    logic [4:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D, RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic ValidD, ValidE;
`ifdef PIPE_FRONT_PERF_EN
    logic [31:0] StallCnt, FlushDCnt, BubbleCnt;
`endif

    pipe_front_regs #(.RESET_PC(RPC), .CTRL_W(CW), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .PCNextF(PCNextF), .InstrF(InstrF), .PCPlus4F(PCPlus4F), .CtrlD(CtrlD),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .CtrlE(CtrlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE)
`ifdef PIPE_FRONT_PERF_EN
        , .StallCnt(StallCnt), .FlushDCnt(FlushDCnt), .BubbleCnt(BubbleCnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    int k = 0;

    // model: what each stage holds, as an instruction record
    logic m_ok = 1'b0;
    logic [31:0] m_pcf, md_instr, md_pc, md_pc4;
    logic md_v;
    logic [CW-1:0] me_ctrl;
    logic [31:0] me_rd1, me_rd2, me_imm, me_pc, me_pc4;
    logic [4:0] me_rs1, me_rs2, me_rd;
    logic me_v;
    logic [31:0] m_sc, m_fc, m_bc;

    function automatic logic [31:0] instr_at(input logic [31:0] pc);
        return pc == 32'h100 ? 32'h00500093 : {pc[19:0], 12'h013};
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ok <= 1'b1;
            m_pcf <= RPC;
            {md_instr, md_pc, md_pc4, md_v} <= {NOP, 65'b0};
            {me_ctrl, me_rd1, me_rd2, me_imm, me_pc, me_pc4, me_rs1, me_rs2, me_rd, me_v} <= '0;
            {m_sc, m_fc, m_bc} <= '0;
        end else begin
            if (!StallF) m_pcf <= PCNextF;
            if (FlushD) {md_instr, md_pc, md_pc4, md_v} <= {NOP, 65'b0};
            else if (!StallD) {md_instr, md_pc, md_pc4, md_v} <= {InstrF, m_pcf, PCPlus4F, 1'b1};
            if (FlushE) {me_ctrl, me_rd1, me_rd2, me_imm, me_pc, me_pc4, me_rs1, me_rs2, me_rd, me_v} <= '0;
            else {me_ctrl, me_rd1, me_rd2, me_imm, me_pc, me_pc4, me_rs1, me_rs2, me_rd, me_v}
                <= {CtrlD, RD1D, RD2D, ImmExtD, md_pc, md_pc4, Rs1D, Rs2D, RdD, md_v};
            m_sc <= m_sc + ((StallD && !FlushD) ? 32'd1 : 32'd0);
            m_fc <= m_fc + (FlushD ? 32'd1 : 32'd0);
            m_bc <= m_bc + ((FlushE && md_v) ? 32'd1 : 32'd0);
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("PCF", PCF, m_pcf);
            chk("InstrD", InstrD, md_instr);
            chk("PCD", PCD, md_pc);
            chk("PCPlus4D", PCPlus4D, md_pc4);
            chk("ValidD", 32'(ValidD), 32'(md_v));
            chk("CtrlE", 32'(CtrlE), 32'(me_ctrl));
            chk("RD1E", RD1E, me_rd1);
            chk("RD2E", RD2E, me_rd2);
            chk("ImmExtE", ImmExtE, me_imm);
            chk("PCE", PCE, me_pc);
            chk("PCPlus4E", PCPlus4E, me_pc4);
            chk("Rs1E", 32'(Rs1E), 32'(me_rs1));
            chk("Rs2E", 32'(Rs2E), 32'(me_rs2));
            chk("RdE", 32'(RdE), 32'(me_rd));
            chk("ValidE", 32'(ValidE), 32'(me_v));
`ifdef PIPE_FRONT_PERF_EN
            chk("StallCnt", StallCnt, m_sc);
            chk("FlushDCnt", FlushDCnt, m_fc);
            chk("BubbleCnt", BubbleCnt, m_bc);
`endif
        end
    end

    task automatic drive(input logic r, input logic sf, input logic sd, input logic fd, input logic fe,
                         input logic [31:0] nxt);
        rst_n = r; StallF = sf; StallD = sd; FlushD = fd; FlushE = fe; PCNextF = nxt;
        PCPlus4F = m_pcf + 32'd4;
        InstrF = instr_at(m_pcf);
        CtrlD = CW'(12'h300 + k);
        RD1D = 32'hA000_0000 + k;
        RD2D = 32'hB000_0000 + k;
        ImmExtD = 32'hC000_0000 + k;
        Rs1D = 5'(k + 1);
        Rs2D = 5'(k + 2);
        RdD = 5'(k);
        k++;
        @(posedge clk);
        #2;
    endtask

    task automatic adv();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, m_pcf + 32'd4);
    endtask

    logic [3:0] pat [16] = '{4'd0, 4'd13, 4'd0, 4'd3, 4'd0, 4'd15, 4'd0, 4'd1,
                             4'd12, 4'd0, 4'd2, 4'd0, 4'd13, 4'd13, 4'd0, 4'd0};

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("rst PCF", PCF, 32'h100);
        chk("rst InstrD", InstrD, 32'h13);
        chk("rst ValidD", 32'(ValidD), 0);
        chk("rst ValidE", 32'(ValidE), 0);
        adv();
        chk("flow PCF", PCF, 32'h104);
        chk("flow InstrD", InstrD, 32'h00500093);
        chk("flow PCD", PCD, 32'h100);
        chk("flow ValidD", 32'(ValidD), 1);
        adv();
        chk("flow2 PCF", PCF, 32'h108);
        chk("flow2 CtrlE", 32'(CtrlE), 32'h303);
        chk("flow2 RdE", 32'(RdE), 3);
        chk("flow2 PCE", PCE, 32'h100);
        chk("flow2 ValidE", 32'(ValidE), 1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, m_pcf + 32'd4);
        chk("lu PCF", PCF, 32'h108);
        chk("lu InstrD", InstrD, 32'h00104013);
        chk("lu ValidD", 32'(ValidD), 1);
        chk("lu ValidE", 32'(ValidE), 0);
        chk("lu CtrlE", 32'(CtrlE), 0);
        adv();
        chk("lu2 CtrlE", 32'(CtrlE), 32'h305);
        chk("lu2 PCE", PCE, 32'h104);
        chk("lu2 ValidE", 32'(ValidE), 1);
        chk("lu2 InstrD", InstrD, 32'h00108013);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200);
        chk("br PCF", PCF, 32'h200);
        chk("br InstrD", InstrD, 32'h13);
        chk("br ValidD", 32'(ValidD), 0);
        chk("br ValidE", 32'(ValidE), 0);
        adv();
        chk("br2 InstrD", InstrD, 32'h00200013);
        chk("br2 ValidE", 32'(ValidE), 0);
        adv();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, m_pcf + 32'd4);
        chk("sim PCF", PCF, 32'h208);
        chk("sim InstrD", InstrD, 32'h13);
        chk("sim ValidD", 32'(ValidD), 0);
        chk("sim ValidE", 32'(ValidE), 1);
        adv();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, m_pcf + 32'd4);
        chk("mrst PCF", PCF, 32'h100);
        chk("mrst InstrD", InstrD, 32'h13);
        chk("mrst ValidD", 32'(ValidD), 0);
        chk("mrst ValidE", 32'(ValidE), 0);
        chk("mrst CtrlE", 32'(CtrlE), 0);
        chk("mrst PCE", PCE, 0);
        for (int i = 0; i < 16; i++)
            drive(1'b1, pat[i][3], pat[i][2], pat[i][1], pat[i][0],
                  pat[i][1] ? m_pcf + 32'h40 : m_pcf + 32'd4);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        adv();
        adv();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, m_pcf + 32'd4);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h300);
        adv();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h400);
        chk("perf PCF", PCF, 32'h400);
`ifdef PIPE_FRONT_PERF_EN
        chk("perf StallCnt", StallCnt, 3);
        chk("perf FlushDCnt", FlushDCnt, 2);
        chk("perf BubbleCnt", BubbleCnt, 5);
`endif
        adv();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
